// File: rtl/imm_ext_pipe_pkg.sv
// ============================================================================
// Module      : imm_ext_pipe_pkg
// Description : Extension-mode codes and skid-buffer occupancy encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imm_ext_pipe_pkg;

    localparam logic [2:0] C_EXTOP_SIGN  = 3'd0;
    localparam logic [2:0] C_EXTOP_ZERO  = 3'd1;
    localparam logic [2:0] C_EXTOP_HIGH  = 3'd2;
    localparam logic [2:0] C_EXTOP_BR    = 3'd3;
    localparam logic [2:0] C_EXTOP_ZHIGH = 3'd4;

    localparam logic [1:0] C_OCC_EMPTY = 2'd0;
    localparam logic [1:0] C_OCC_ONE   = 2'd1;
    localparam logic [1:0] C_OCC_FULL  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/imm_ext_pipe_core.sv
// ============================================================================
// Module      : imm_ext_core
// Description : Combinational immediate extender, five modes plus illegal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_ext_core
    import imm_ext_pipe_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int OP_W  = 3
) (
    input  logic [IN_W-1:0]  in_imm,
    input  logic [OP_W-1:0]  in_op,
    output logic [OUT_W-1:0] imm,
    output logic             illegal
);

    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_zext;

    assign w_sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
    assign w_zext = {{(OUT_W-IN_W){1'b0}}, in_imm};

    // Shifted modes drop the top two bits so the width stays OUT_W.
    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        case (in_op)
            OP_W'(C_EXTOP_SIGN):  imm = w_sext;
            OP_W'(C_EXTOP_ZERO):  imm = w_zext;
            OP_W'(C_EXTOP_HIGH):  imm = {in_imm, {(OUT_W-IN_W){1'b0}}};
            OP_W'(C_EXTOP_BR):    imm = {w_sext[OUT_W-3:0], 2'b00};
            OP_W'(C_EXTOP_ZHIGH): imm = {w_zext[OUT_W-3:0], 2'b00};
            default:              illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/imm_ext_pipe.sv
// ============================================================================
// Module      : imm_ext_pipe
// Description : Immediate extender registered into a 2-entry valid/ready skid
//               buffer carrying an opaque tag; flushable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_ext_pipe
    import imm_ext_pipe_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int OP_W  = 3,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [OP_W-1:0]  in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    logic [OUT_W-1:0] w_ext_imm;
    logic             w_ext_ill;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .OP_W  (OP_W)
    ) u_core (
        .in_imm  (in_imm),
        .in_op   (in_op),
        .imm     (w_ext_imm),
        .illegal (w_ext_ill)
    );

    logic [1:0]       r_occ;
    logic             r_in_ready;
    logic [OUT_W-1:0] r_main_imm;
    logic [TAG_W-1:0] r_main_tag;
    logic             r_main_ill;
    logic [OUT_W-1:0] r_skid_imm;
    logic [TAG_W-1:0] r_skid_tag;
    logic             r_skid_ill;

    logic       w_in_fire;
    logic       w_out_fire;
    logic [1:0] w_occ_nxt;
    logic       w_ld_main_in;
    logic       w_ld_main_skid;
    logic       w_ld_skid;

    assign out_valid   = (r_occ != C_OCC_EMPTY);
    assign in_ready    = r_in_ready;
    assign out_imm     = r_main_imm;
    assign out_tag     = r_main_tag;
    assign out_illegal = r_main_ill;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_comb begin
        w_occ_nxt      = r_occ;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        case (r_occ)
            C_OCC_EMPTY: begin
                if (w_in_fire) begin
                    w_ld_main_in = 1'b1;
                    w_occ_nxt    = C_OCC_ONE;
                end
            end
            C_OCC_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_ld_main_in = 1'b1;
                end else if (w_in_fire) begin
                    w_ld_skid = 1'b1;
                    w_occ_nxt = C_OCC_FULL;
                end else if (w_out_fire) begin
                    w_occ_nxt = C_OCC_EMPTY;
                end
            end
            C_OCC_FULL: begin
                // in_ready is low here, so only the drain side can move.
                if (w_out_fire) begin
                    w_ld_main_skid = 1'b1;
                    w_occ_nxt      = C_OCC_ONE;
                end
            end
            default: w_occ_nxt = C_OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ      <= C_OCC_EMPTY;
            r_in_ready <= 1'b1;
            r_main_imm <= '0;
            r_main_tag <= '0;
            r_main_ill <= 1'b0;
            r_skid_imm <= '0;
            r_skid_tag <= '0;
            r_skid_ill <= 1'b0;
        end else if (flush) begin
            r_occ      <= C_OCC_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_occ      <= w_occ_nxt;
            r_in_ready <= (w_occ_nxt != C_OCC_FULL);
            if (w_ld_main_in) begin
                r_main_imm <= w_ext_imm;
                r_main_tag <= in_tag;
                r_main_ill <= w_ext_ill;
            end else if (w_ld_main_skid) begin
                r_main_imm <= r_skid_imm;
                r_main_tag <= r_skid_tag;
                r_main_ill <= r_skid_ill;
            end
            if (w_ld_skid) begin
                r_skid_imm <= w_ext_imm;
                r_skid_tag <= in_tag;
                r_skid_ill <= w_ext_ill;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imm_ext_pipe.sv
// ============================================================================
// Module      : tb_imm_ext_pipe
// Description : Directed self-checking bench for imm_ext_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [2:0]  in_op;
    logic [31:0] in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [31:0] out_tag;
    logic        out_illegal;

    int vectors    = 0;
    int miscompares = 0;

    imm_ext_pipe dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_imm      (in_imm),
        .in_op       (in_op),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_tag     (out_tag),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] imm, input logic [2:0] op, input logic [31:0] tag);
        in_valid = 1'b1;
        in_imm   = imm;
        in_op    = op;
        in_tag   = tag;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_imm = '0; in_op = '0; in_tag = '0;
        step(); step();
        vectors++;
        if ({out_valid, in_ready, out_imm, out_tag, out_illegal} !== {1'b0, 1'b1, 32'h0, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b ready=%b imm=%h tag=%h ill=%b want 0 1 0 0 0",
                     out_valid, in_ready, out_imm, out_tag, out_illegal);
        end
        reset = 1'b0;
        step();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_modes();
        logic [15:0] imms [5] = '{16'h8000, 16'h8000, 16'h1234, 16'hFFFF, 16'h4001};
        logic [31:0] exps [5] = '{32'hFFFF8000, 32'h00008000, 32'h12340000, 32'hFFFFFFFC, 32'h00010004};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(imms[i], 3'(i), 32'h100 + 32'(4*i));
            step();
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_imm !== exps[i] ||
                out_tag !== 32'h100 + 32'(4*i) || out_illegal !== 1'b0) begin
                miscompares++;
                $display("FAIL mode_%0d: valid=%b ready=%b imm=%h tag=%h ill=%b want 1 1 %h %h 0",
                         i, out_valid, in_ready, out_imm, out_tag, out_illegal, exps[i], 32'h100 + 32'(4*i));
            end
        end
        in_valid = 1'b0;
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL modes_drain: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        push(16'h00FF, 3'd7, 32'h3000);
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_imm !== 32'h0 || out_illegal !== 1'b1 || out_tag !== 32'h3000) begin
            miscompares++;
            $display("FAIL illegal_op: valid=%b imm=%h ill=%b tag=%h want 1 0 1 3000",
                     out_valid, out_imm, out_illegal, out_tag);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        push(16'h0001, 3'd0, 32'h10);                 // A
        step();
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_tag !== 32'h10) begin
            miscompares++;
            $display("FAIL bp_accept_a: valid=%b ready=%b tag=%h want 1 1 10", out_valid, in_ready, out_tag);
        end
        push(16'h0002, 3'd0, 32'h14);                 // B
        step();
        vectors++;
        if (in_ready !== 1'b0 || out_tag !== 32'h10 || out_imm !== 32'h1) begin
            miscompares++;
            $display("FAIL bp_full: ready=%b tag=%h imm=%h want 0 10 1", in_ready, out_tag, out_imm);
        end
        push(16'h0003, 3'd0, 32'h18);                 // C, must be held
        step();
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 32'h10 || out_imm !== 32'h1) begin
            miscompares++;
            $display("FAIL bp_hold: ready=%b valid=%b tag=%h imm=%h want 0 1 10 1",
                     in_ready, out_valid, out_tag, out_imm);
        end
        out_ready = 1'b1;
        step();                                        // A leaves, B to main
        vectors++;
        if (out_valid !== 1'b1 || out_tag !== 32'h14 || out_imm !== 32'h2 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_out_b: valid=%b tag=%h imm=%h ready=%b want 1 14 2 1",
                     out_valid, out_tag, out_imm, in_ready);
        end
        step();                                        // B leaves, C accepted
        vectors++;
        if (out_valid !== 1'b1 || out_tag !== 32'h18 || out_imm !== 32'h3) begin
            miscompares++;
            $display("FAIL bp_out_c: valid=%b tag=%h imm=%h want 1 18 3", out_valid, out_tag, out_imm);
        end
        in_valid = 1'b0;
        step();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_drain: valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(16'(i * 3), 3'd1, 32'(i));
            step();
            vectors++;
            if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_tag !== 32'(i) || out_imm !== 32'(i * 3)) begin
                miscompares++;
                $display("FAIL stream_%0d: ready=%b valid=%b tag=%h imm=%h want 1 1 %h %h",
                         i, in_ready, out_valid, out_tag, out_imm, 32'(i), 32'(i * 3));
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        push(16'h00A0, 3'd1, 32'hA0); step();
        push(16'h00A4, 3'd1, 32'hA4); step();
        push(16'h00A8, 3'd1, 32'hA8);                 // presented while full
        flush = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_full: valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
        flush = 1'b0;
        push(16'h00B0, 3'd1, 32'hB0); step();         // occupancy 1
        push(16'h00B4, 3'd1, 32'hB4);                 // accepted in flush cycle
        flush = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_infire: valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
        flush = 1'b0;
        out_ready = 1'b1;
        push(16'hFFFE, 3'd2, 32'hC0);
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_tag !== 32'hC0 || out_imm !== 32'hFFFE0000) begin
            miscompares++;
            $display("FAIL flush_after: valid=%b tag=%h imm=%h want 1 c0 fffe0000", out_valid, out_tag, out_imm);
        end
        in_valid = 1'b0;
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_drain: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        push(16'h1111, 3'd6, 32'hD0); step();         // illegal entry at head
        push(16'h2222, 3'd0, 32'hD4); step();
        reset = 1'b1;
        flush = 1'b1;
        step();
        vectors++;
        if ({out_valid, in_ready, out_imm, out_tag, out_illegal} !== {1'b0, 1'b1, 32'h0, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid: valid=%b ready=%b imm=%h tag=%h ill=%b want 0 1 0 0 0",
                     out_valid, in_ready, out_imm, out_tag, out_illegal);
        end
        reset = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        push(16'h7FFF, 3'd0, 32'hE0);
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_imm !== 32'h00007FFF || out_tag !== 32'hE0 || out_illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_after: valid=%b imm=%h tag=%h ill=%b want 1 00007fff e0 0",
                     out_valid, out_imm, out_tag, out_illegal);
        end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_modes();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
